// File: rtl/ama_riscv_hpm_unit.sv
// Parametrised hardware performance monitor: NUM_CNT event counters with
// inhibit, sticky overflow, freeze-on-overflow and an overflow interrupt.
module ama_riscv_hpm_unit #(
    parameter int NUM_CNT = 6,
    parameter int NUM_EVT = 8,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_re,
    input  logic               csr_we,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_hit,
    input  logic [NUM_EVT-1:0] events,
    output logic               ovf_irq
);

    localparam int SEL_W = $clog2(NUM_EVT + 1);

    localparam logic [11:0] ADDR_CNT_LO = 12'hB03;
    localparam logic [11:0] ADDR_CNT_HI = 12'hB83;
    localparam logic [11:0] ADDR_EVT    = 12'h323;
    localparam logic [11:0] ADDR_INH    = 12'h320;
    localparam logic [11:0] ADDR_OVF    = 12'h7C0;

    logic [CNT_W-1:0]   cnt [NUM_CNT];
    logic [SEL_W-1:0]   sel [NUM_CNT];
    logic [NUM_CNT-1:0] ofie;
    logic [NUM_CNT-1:0] freeze;
    logic [NUM_CNT-1:0] inhibit;
    logic [NUM_CNT-1:0] ovf;
    logic [NUM_EVT-1:0] evt_q;

    logic               hit;
    logic [31:0]        rd_raw;
    logic [NUM_CNT-1:0] hit_lo;
    logic [NUM_CNT-1:0] hit_hi;
    logic [NUM_CNT-1:0] hit_evt;
    logic               hit_inh;
    logic               hit_ovf;
    logic [31:0]        wval;
    logic               wr;
    logic [NUM_CNT-1:0] evt_hit;
    logic [NUM_CNT-1:0] inc;
    logic [NUM_CNT-1:0] ovf_set;
    logic [NUM_CNT-1:0] ovf_next;

    // Address decode and read mux; rd_raw ignores csr_re so RS/RC can use it.
    always_comb begin
        hit     = 1'b0;
        rd_raw  = '0;
        hit_lo  = '0;
        hit_hi  = '0;
        hit_evt = '0;
        hit_inh = 1'b0;
        hit_ovf = 1'b0;
        if (csr_addr == ADDR_INH) begin
            hit     = 1'b1;
            hit_inh = 1'b1;
            rd_raw  = 32'(inhibit) << 3;
        end
        if (csr_addr == ADDR_OVF) begin
            hit     = 1'b1;
            hit_ovf = 1'b1;
            rd_raw  = 32'(ovf) << 3;
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            if (csr_addr == 12'(ADDR_CNT_LO + i)) begin
                hit       = 1'b1;
                hit_lo[i] = 1'b1;
                rd_raw    = cnt[i][31:0];
            end
            if (csr_addr == 12'(ADDR_CNT_HI + i)) begin
                hit       = 1'b1;
                hit_hi[i] = 1'b1;
                rd_raw    = 32'(cnt[i] >> 32);
            end
            if (csr_addr == 12'(ADDR_EVT + i)) begin
                hit        = 1'b1;
                hit_evt[i] = 1'b1;
                rd_raw     = (32'(ofie[i]) << 31) | (32'(freeze[i]) << 30) | 32'(sel[i]);
            end
        end
    end

    assign csr_hit   = hit;
    assign csr_rdata = csr_re ? rd_raw : 32'h0;

    always_comb begin
        case (csr_op)
            2'd0:    wval = csr_wdata;
            2'd1:    wval = rd_raw | csr_wdata;
            2'd2:    wval = rd_raw & ~csr_wdata;
            default: wval = rd_raw;
        endcase
    end

    assign wr = csr_we && (csr_op != 2'd3) && hit;

    // A software write to either counter half takes the slot of the increment.
    always_comb begin
        evt_hit = '0;
        inc     = '0;
        ovf_set = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            for (int e = 0; e < NUM_EVT; e++) begin
                if (sel[i] == SEL_W'(e + 1)) evt_hit[i] = evt_q[e];
            end
            inc[i] = evt_hit[i] && !inhibit[i] && !(freeze[i] && ovf[i])
                     && !(wr && (hit_lo[i] || hit_hi[i]));
            ovf_set[i] = inc[i] && (&cnt[i]);
        end
        ovf_next = ((wr && hit_ovf) ? wval[NUM_CNT+2:3] : ovf) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt[i] <= '0;
                sel[i] <= '0;
            end
            ofie    <= '0;
            freeze  <= '0;
            inhibit <= '0;
            ovf     <= '0;
            evt_q   <= '0;
            ovf_irq <= 1'b0;
        end else begin
            evt_q <= events;
            for (int i = 0; i < NUM_CNT; i++) begin
                if (wr && hit_lo[i]) begin
                    cnt[i][31:0] <= wval;
                end else if (wr && hit_hi[i]) begin
                    cnt[i][CNT_W-1:32] <= wval[CNT_W-33:0];
                end else if (inc[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                if (wr && hit_evt[i]) begin
                    sel[i]    <= wval[SEL_W-1:0];
                    freeze[i] <= wval[30];
                    ofie[i]   <= wval[31];
                end
            end
            if (wr && hit_inh) inhibit <= wval[NUM_CNT+2:3];
            ovf     <= ovf_next;
            ovf_irq <= |(ovf_next & ofie);
        end
    end

endmodule

// File: tb/tb_ama_riscv_hpm_unit.sv
// Scoreboard bench for ama_riscv_hpm_unit (40-bit counters): directed CSR
// accesses push expected read data / irq levels, a monitor compares them.
module tb_ama_riscv_hpm_unit;

    logic        clk;
    logic        rst;
    logic        csr_re;
    logic        csr_we;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic [7:0]  events;
    logic        ovf_irq;
    logic        chk_irq;

    typedef struct {
        string       name;
        logic        is_irq;
        logic        exp_hit;
        logic [31:0] exp_data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    ama_riscv_hpm_unit #(.NUM_CNT(6), .NUM_EVT(8), .CNT_W(40)) dut (
        .clk       (clk),
        .rst       (rst),
        .csr_re    (csr_re),
        .csr_we    (csr_we),
        .csr_op    (csr_op),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .csr_hit   (csr_hit),
        .events    (events),
        .ovf_irq   (ovf_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares at the falling edge whenever an access or irq probe is live.
    initial begin
        forever begin
            @(negedge clk);
            if (csr_re || chk_irq) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: no expected entry queued, rdata=%h irq=%b", csr_rdata, ovf_irq);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.is_irq) begin
                        if (ovf_irq !== mon_e.exp_data[0]) begin
                            errors++;
                            $display("FAIL %s: ovf_irq=%b expected %b", mon_e.name, ovf_irq, mon_e.exp_data[0]);
                        end
                    end else if (csr_rdata !== mon_e.exp_data || csr_hit !== mon_e.exp_hit) begin
                        errors++;
                        $display("FAIL %s: rdata=%h hit=%b expected rdata=%h hit=%b",
                                 mon_e.name, csr_rdata, csr_hit, mon_e.exp_data, mon_e.exp_hit);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] op);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        csr_op    = op;
        cycle();
        csr_we    = 1'b0;
        csr_op    = 2'd0;
        csr_wdata = 32'h0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input logic h, input string n);
        exp_t e;
        e.name     = n;
        e.is_irq   = 1'b0;
        e.exp_hit  = h;
        e.exp_data = exp;
        sb.push_back(e);
        csr_re   = 1'b1;
        csr_addr = a;
        cycle();
        csr_re   = 1'b0;
    endtask

    task automatic irq(input logic exp, input string n);
        exp_t e;
        e.name     = n;
        e.is_irq   = 1'b1;
        e.exp_hit  = 1'b0;
        e.exp_data = {31'h0, exp};
        sb.push_back(e);
        chk_irq = 1'b1;
        cycle();
        chk_irq = 1'b0;
    endtask

    initial begin
        rst = 1'b1; csr_re = 1'b0; csr_we = 1'b0; csr_op = 2'd0;
        csr_addr = 12'h0; csr_wdata = 32'h0; events = 8'h0; chk_irq = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;

        // Reset state of every implemented register
        for (int i = 0; i < 6; i++) begin
            rd(12'(12'hB03 + i), 32'h0, 1'b1, "reset_cnt_lo");
            rd(12'(12'hB83 + i), 32'h0, 1'b1, "reset_cnt_hi");
            rd(12'(12'h323 + i), 32'h0, 1'b1, "reset_event");
        end
        rd(12'h320, 32'h0, 1'b1, "reset_inhibit");
        rd(12'h7C0, 32'h0, 1'b1, "reset_hpmovf");
        rd(12'hB00, 32'h0, 1'b0, "unimpl_b00");
        rd(12'hB89, 32'h0, 1'b0, "unimpl_b89");
        irq(1'b0, "reset_irq");

        // Five event pulses on sel=1; counter4 has an out-of-range select
        wr(12'h323, 32'h1, 2'd0);
        wr(12'h324, 32'hF, 2'd0);
        events = 8'hFF;
        repeat (5) cycle();
        events = 8'h00;
        cycle();
        rd(12'hB03, 32'd5, 1'b1, "count5_lo");
        rd(12'hB83, 32'd0, 1'b1, "count5_hi");
        rd(12'hB04, 32'd0, 1'b1, "sel_out_of_range_cnt4");
        rd(12'h324, 32'hF, 1'b1, "sel_out_of_range_readback");

        // Inhibit counter3, then release it with the event still high
        wr(12'h320, 32'h8, 2'd0);
        events = 8'h01;
        repeat (10) cycle();
        rd(12'hB03, 32'd5, 1'b1, "inhibited_cnt");
        rd(12'h320, 32'h8, 1'b1, "inhibit_readback");
        wr(12'h320, 32'h0, 2'd0);
        rd(12'hB03, 32'd5, 1'b1, "uninhibit_first");
        rd(12'hB03, 32'd6, 1'b1, "uninhibit_plus1");
        rd(12'hB03, 32'd7, 1'b1, "uninhibit_plus2");
        events = 8'h00;
        cycle();
        cycle();
        rd(12'hB03, 32'd9, 1'b1, "uninhibit_drain");

        // 40-bit wrap with OFIE
        wr(12'hB83, 32'hFF, 2'd0);
        wr(12'hB03, 32'hFFFF_FFFE, 2'd0);
        wr(12'h323, 32'h8000_0001, 2'd0);
        rd(12'hB03, 32'hFFFF_FFFE, 1'b1, "preset_lo");
        rd(12'hB83, 32'hFF, 1'b1, "preset_hi");
        rd(12'h323, 32'h8000_0001, 1'b1, "event_ofie_readback");
        events = 8'h01; cycle(); events = 8'h00; cycle();
        rd(12'hB03, 32'hFFFF_FFFF, 1'b1, "allones_lo");
        rd(12'hB83, 32'hFF, 1'b1, "allones_hi");
        rd(12'h7C0, 32'h0, 1'b1, "no_ovf_at_lo_wrap");
        irq(1'b0, "irq_before_wrap");
        events = 8'h01; cycle(); events = 8'h00; cycle();
        rd(12'hB03, 32'h0, 1'b1, "wrap_lo");
        rd(12'hB83, 32'h0, 1'b1, "wrap_hi");
        rd(12'h7C0, 32'h8, 1'b1, "wrap_hpmovf");
        irq(1'b1, "wrap_irq");
        wr(12'h7C0, 32'h8, 2'd2);
        irq(1'b0, "irq_after_clear");
        rd(12'h7C0, 32'h0, 1'b1, "hpmovf_cleared");

        // Freeze on overflow, then resume after clearing hpmovf
        wr(12'h323, 32'hC000_0001, 2'd0);
        wr(12'hB83, 32'hFF, 2'd0);
        wr(12'hB03, 32'hFFFF_FFFF, 2'd0);
        events = 8'h01;
        repeat (5) cycle();
        rd(12'hB03, 32'h0, 1'b1, "frozen_lo");
        rd(12'h7C0, 32'h8, 1'b1, "frozen_hpmovf");
        irq(1'b1, "frozen_irq");
        wr(12'h7C0, 32'h8, 2'd2);
        rd(12'hB03, 32'd0, 1'b1, "resume_first");
        rd(12'hB03, 32'd1, 1'b1, "resume_plus1");
        rd(12'hB03, 32'd2, 1'b1, "resume_plus2");
        events = 8'h00;
        cycle();
        cycle();

        // Software write beats a due increment; RS/RC/reserved ops on an event reg
        wr(12'h323, 32'h1, 2'd0);
        events = 8'h01; cycle(); events = 8'h00;
        wr(12'hB03, 32'h100, 2'd0);
        rd(12'hB03, 32'h100, 1'b1, "write_beats_inc");
        rd(12'h7C0, 32'h0, 1'b1, "write_no_ovf");
        wr(12'h325, 32'h1, 2'd0);
        wr(12'h325, 32'h2, 2'd1);
        rd(12'h325, 32'h3, 1'b1, "rs_event5");
        wr(12'h325, 32'h1, 2'd2);
        rd(12'h325, 32'h2, 1'b1, "rc_event5");
        wr(12'h325, 32'hFF, 2'd3);
        rd(12'h325, 32'h2, 1'b1, "op3_no_write");
        wr(12'h325, 32'hFFFF_FFFF, 2'd0);
        rd(12'h325, 32'hC000_000F, 1'b1, "event_unimpl_bits");

        repeat (2) cycle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
